// File: rtl/rf_wb_pkg.sv
// Shared widths, entry type and default queue depth for the register-file write-back arbiter.
package rf_wb_pkg;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_REGS   = 32;
    localparam int WB_DEPTH  = 4;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [RF_REGS-1:0] rd_onehot(input logic [RF_ADDR_W-1:0] rd);
        rd_onehot = {{(RF_REGS-1){1'b0}}, 1'b1} << rd;
    endfunction
endpackage

// File: rtl/rf_wb_if.sv
// Result handshakes, register-file write port and scoreboard of the write-back arbiter.
// Forwarding lookup signals exist only when RF_WB_FWD_EN is defined.
interface rf_wb_if;
    import rf_wb_pkg::*;

    logic                 alu_valid;
    logic                 alu_ready;
    logic [RF_ADDR_W-1:0] alu_rd;
    logic [RF_DATA_W-1:0] alu_data;
    logic                 lsu_valid;
    logic                 lsu_ready;
    logic [RF_ADDR_W-1:0] lsu_rd;
    logic [RF_DATA_W-1:0] lsu_data;
    logic                 wb_stall;
    logic                 rf_we;
    logic [RF_ADDR_W-1:0] rf_waddr;
    logic [RF_DATA_W-1:0] rf_wdata;
    logic [RF_REGS-1:0]   pending;
`ifdef RF_WB_FWD_EN
    logic [RF_ADDR_W-1:0] fwd_raddr_1;
    logic [RF_ADDR_W-1:0] fwd_raddr_2;
    logic                 fwd_hit_1;
    logic                 fwd_hit_2;
    logic [RF_DATA_W-1:0] fwd_data_1;
    logic [RF_DATA_W-1:0] fwd_data_2;

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, wb_stall,
        input  fwd_raddr_1, fwd_raddr_2,
        output alu_ready, lsu_ready, rf_we, rf_waddr, rf_wdata, pending,
        output fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2
    );
    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, wb_stall,
        output fwd_raddr_1, fwd_raddr_2,
        input  alu_ready, lsu_ready, rf_we, rf_waddr, rf_wdata, pending,
        input  fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2
    );
`else
    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, wb_stall,
        output alu_ready, lsu_ready, rf_we, rf_waddr, rf_wdata, pending
    );
    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, wb_stall,
        input  alu_ready, lsu_ready, rf_we, rf_waddr, rf_wdata, pending
    );
`endif
endinterface

// File: rtl/rf_wb_fifo.sv
// In-order write queue of wb_entry_t; exposes every slot and its valid bit for scoreboard/forwarding.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int   DEPTH = WB_DEPTH,
    localparam int  PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  wb_entry_t        push_entry_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output wb_entry_t        entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [PTR_W:0]   count_o
);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // Next-state: pop clears the head slot, push fills the tail slot.
    always_comb begin
        mem_d    = mem_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (pop_i) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_i) begin
            mem_d[wr_ptr_q]   = push_entry_i;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Queue state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {(RF_ADDR_W+RF_DATA_W){1'b0}};
            end
            valid_q  <= {DEPTH{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign entries_o = mem_q;
    assign valid_o   = valid_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign count_o   = count_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: LSU-priority accept, in-order queue, registered RF write port, pending scoreboard.
// Optional forwarding lookup enabled by defining RF_WB_FWD_EN.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input logic    clk,
    input logic    rst,
    rf_wb_if.slave bus
);
    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    wb_entry_t            entries_s [DEPTH];
    logic [DEPTH-1:0]     valid_s;
    logic [PTR_W-1:0]     rd_ptr_s;
    logic [PTR_W:0]       count_s;
    wb_entry_t            head_s;
    wb_entry_t            acc_entry_s;
    logic                 full_s, empty_s, lsu_acc_s, alu_acc_s, keep_s;
    logic                 pop_s, push_s, bypass_s;
    logic                 rf_we_q, rf_we_d;
    logic [RF_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [RF_DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [RF_REGS-1:0]   pending_s;

    assign full_s        = (count_s == CNT_FULL);
    assign empty_s       = (count_s == {(PTR_W+1){1'b0}});
    assign bus.lsu_ready = !full_s && !rst;
    assign bus.alu_ready = !full_s && !bus.lsu_valid && !rst;

    // Accept/drain decision; an accept into an empty unstalled queue goes straight to the port.
    always_comb begin
        lsu_acc_s = bus.lsu_valid && bus.lsu_ready;
        alu_acc_s = bus.alu_valid && bus.alu_ready;
        if (lsu_acc_s) begin
            acc_entry_s = '{rd: bus.lsu_rd, data: bus.lsu_data};
        end else begin
            acc_entry_s = '{rd: bus.alu_rd, data: bus.alu_data};
        end
        keep_s   = (lsu_acc_s || alu_acc_s) && (acc_entry_s.rd != {RF_ADDR_W{1'b0}});
        pop_s    = !empty_s && !bus.wb_stall;
        bypass_s = keep_s && empty_s && !bus.wb_stall;
        push_s   = keep_s && !bypass_s;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rf_we_d    = 1'b0;
        if (pop_s) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head_s.rd;
            rf_wdata_d = head_s.data;
        end else if (bypass_s) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = acc_entry_s.rd;
            rf_wdata_d = acc_entry_s.data;
        end else begin
            rf_we_d = 1'b0;
        end
    end

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push_s),
        .push_entry_i (acc_entry_s),
        .pop_i        (pop_s),
        .head_o       (head_s),
        .entries_o    (entries_s),
        .valid_o      (valid_s),
        .rd_ptr_o     (rd_ptr_s),
        .count_o      (count_s)
    );

    // Register-file write port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= {RF_ADDR_W{1'b0}};
            rf_wdata_q <= {RF_DATA_W{1'b0}};
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;

    // Scoreboard: every queued destination plus the one currently on the write port.
    always_comb begin
        pending_s = {RF_REGS{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_s[i]) begin
                pending_s = pending_s | rd_onehot(entries_s[i].rd);
            end else begin
                pending_s = pending_s;
            end
        end
        if (rf_we_q) begin
            pending_s = pending_s | rd_onehot(rf_waddr_q);
        end else begin
            pending_s = pending_s;
        end
    end

    assign bus.pending = pending_s;

`ifdef RF_WB_FWD_EN
    // Scans write port first, then queue oldest to newest, so the youngest match wins.
    function automatic logic [RF_DATA_W:0] fwd_lookup(input logic [RF_ADDR_W-1:0] raddr);
        logic                 hit;
        logic [RF_DATA_W-1:0] data;
        logic [PTR_W-1:0]     idx;
        hit  = 1'b0;
        data = {RF_DATA_W{1'b0}};
        if (rf_we_q && (rf_waddr_q == raddr)) begin
            hit  = 1'b1;
            data = rf_wdata_q;
        end else begin
            hit = 1'b0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_s + PTR_W'(k);
            if (valid_s[idx] && (entries_s[idx].rd == raddr)) begin
                hit  = 1'b1;
                data = entries_s[idx].data;
            end else begin
                hit = hit;
            end
        end
        if (raddr == {RF_ADDR_W{1'b0}}) begin
            hit  = 1'b0;
            data = {RF_DATA_W{1'b0}};
        end else begin
            hit = hit;
        end
        return {hit, data};
    endfunction

    logic [RF_DATA_W:0] fwd_1_s, fwd_2_s;

    // Both forwarding lookups.
    always_comb begin
        fwd_1_s = fwd_lookup(bus.fwd_raddr_1);
        fwd_2_s = fwd_lookup(bus.fwd_raddr_2);
    end

    assign bus.fwd_hit_1  = fwd_1_s[RF_DATA_W];
    assign bus.fwd_data_1 = fwd_1_s[RF_DATA_W-1:0];
    assign bus.fwd_hit_2  = fwd_2_s[RF_DATA_W];
    assign bus.fwd_data_2 = fwd_2_s[RF_DATA_W-1:0];
`else
    logic unused_fwd_s;

    // Queue data and head pointer only feed forwarding, which is compiled out here.
    always_comb begin
        unused_fwd_s = ^rd_ptr_s;
        for (int i = 0; i < DEPTH; i++) begin
            unused_fwd_s = unused_fwd_s ^ (^entries_s[i].data);
        end
    end
`endif
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back side of the 32x32 integer register file: collects results from the ALU and load/store unit, queues them in order, and drives the register file's single write port (we/waddr/wdata). It also exports a pending-write scoreboard for the hazard unit. An optional forwarding lookup returns queued-but-unwritten data. It sits between the execute/memory stages and the register file.

## Interface
- DEPTH, 4, write-queue entries; power of two, minimum 2
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alu_valid / alu_ready  in / out  1  ALU result handshake
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- lsu_valid / lsu_ready  in / out  1  load result handshake
- lsu_rd  in  5  load destination register
- lsu_data  in  32  load data
- wb_stall  in  1  write port borrowed by another master; hold the drain
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  write address (registered)
- rf_wdata  out  32  write data (registered)
- pending  out  32  bit r set while a write to register r is queued or on rf_*
- fwd_raddr_1, fwd_raddr_2  in  5  lookup addresses (macro only)
- fwd_hit_1, fwd_hit_2  out  1  lookup hit (macro only)
- fwd_data_1, fwd_data_2  out  32  youngest matching data (macro only)

## Operation
- A handshake completes when valid && ready at a clk edge. LSU has fixed priority.
- lsu_ready = !full && !rst. alu_ready = !full && !lsu_valid && !rst. At most one accept per cycle.
- ready depends only on occupancy; a same-cycle pop does not free a slot for a same-cycle push.
- rd == 0: the handshake completes, the entry is discarded and never enqueued, and pending[0] stays 0.
- Drain: if the queue is not empty and wb_stall = 0, pop the head into rf_*, with rf_we = 1 for exactly that cycle. Otherwise rf_we = 0, and rf_waddr/rf_wdata hold their last values.
- Writes reach the register file in acceptance order, including repeated writes to the same rd.
- pending = OR over the valid queue entries of (1 << rd), OR (rf_we ? 1 << rf_waddr : 0). It is combinational from state.

## Timing
- Reset: queue empty, rf_we = 0, rf_waddr = 0, rf_wdata = 0, pending = 0, both ready = 0 while rst is high.
- Reset mid-operation flushes all queued entries with no write issued. Ready rises in the first cycle after rst deasserts.
- Latency: accepted at edge N into an empty queue with no stall gives rf_we = 1 in cycle N+1. The register file updates at edge N+2.
- Throughput: one write per cycle when unstalled.
- Full: count == DEPTH, so both ready = 0. Empty: count == 0, so no rf_we.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

## Configuration
- RF_WB_FWD_EN defined:
  - the fwd_* ports exist;
  - fwd_hit_k = 1 when fwd_raddr_k != 0 and it matches a queue entry or an asserted rf_*;
  - fwd_data_k is the youngest match, with queue tail taking precedence over older entries and over rf_*;
  - both lookups are combinational.
- RF_WB_FWD_EN undefined:
  - the fwd_* ports are absent;
  - there is no comparator logic;
  - the hazard unit stalls on pending instead.

## Structure
- Package rf_wb_pkg holds:
  - RF_ADDR_W = 5 and RF_DATA_W = 32;
  - the typedef wb_entry_t {rd, data};
  - the default DEPTH constant.
- Sub-module rf_wb_fifo: a generic DEPTH-entry FIFO of wb_entry_t that exposes its entry array and valid bits for the pending and forwarding logic. The arbitration and output register live in the top.

## Test plan
- ALU rd=5, data 0xDEADBEEF accepted at edge N, no stall -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle N+1; pending[5]=1 in cycles N+1 only (queue bypassed on drain); rf_we=0 in N+2.
- Both valid in the same cycle (lsu rd=3/0x11, alu rd=4/0x22) -> alu_ready=0 and LSU accepted first; ALU accepted the next cycle; writes occur in order 3 then 4 on consecutive cycles.
- wb_stall=1 with 4 ALU writes (rd 1..4) -> after 4 accepts, both ready=0 and pending=0x1E. Release the stall -> 4 consecutive writes in order, then ready=1.
- ALU rd=0, data 0xFFFFFFFF -> handshake completes, no rf_we ever, pending stays 0.
- With RF_WB_FWD_EN: stall, enqueue rd=7/0xA then rd=7/0xB, set fwd_raddr_1=7 -> fwd_hit_1=1, fwd_data_1=0xB. fwd_raddr_2=0 -> fwd_hit_2=0.
- Stall, enqueue 3 entries, pulse rst mid-queue -> rf_we=0, pending=0, no write after release, and ready=1 the cycle after rst falls.
